// File: rtl/red_d_pkg.sv
// Constants shared by the Barrett reduction pipeline for q = 8380417.
// RED_D_PIPE_EN adds one register stage, which raises LATENCY from 2 to 3.
package red_d_pkg;

    localparam int unsigned PROD_W = 46;
    localparam int unsigned RES_W  = 23;
    localparam int unsigned K      = 46;
    localparam int unsigned QHAT_W = 24;
    // Width of the remainder before correction; r < 3q < 2^25.
    localparam int unsigned R_W    = 25;

    localparam logic [RES_W-1:0]  Q = 23'd8380417;
    localparam logic [QHAT_W-1:0] M = 24'd8396807;

`ifdef RED_D_PIPE_EN
    localparam int unsigned LATENCY = 3;
`else
    localparam int unsigned LATENCY = 2;
`endif

    // Quotient estimate floor(x * M / 2^K); undershoots floor(x / q) by at most 2.
    function automatic logic [QHAT_W-1:0] barrett_qhat(input logic [PROD_W-1:0] x);
        return QHAT_W'(({{QHAT_W{1'b0}}, x} * {{PROD_W{1'b0}}, M}) >> K);
    endfunction

    // Low R_W bits of qhat * q; enough because the true remainder fits in R_W bits.
    function automatic logic [R_W-1:0] qhat_times_q(input logic [QHAT_W-1:0] qhat);
        return R_W'({1'b0, qhat} * {{(R_W - RES_W){1'b0}}, Q});
    endfunction

endpackage

// File: rtl/red_d_csub.sv
// Combinational conditional subtract: returns value - q when value >= q, else value.
module red_d_csub
    import red_d_pkg::*;
(
    input  logic [R_W-1:0] value,
    output logic [R_W-1:0] reduced
);

    localparam logic [R_W-1:0] QWide = {{(R_W - RES_W){1'b0}}, Q};

    always_comb begin
        reduced = value;
        if (value >= QWide) begin
            reduced = value - QWide;
        end
    end

endmodule

// File: rtl/red_d.sv
// Pipelined Barrett reduction of a 46-bit product modulo q = 8380417.
// Define RED_D_PIPE_EN to register qhat*q before the subtraction (latency 3 instead of 2).
module red_d
    import red_d_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    input  logic [PROD_W-1:0] product_i,
    output logic              valid_o,
    output logic [RES_W-1:0]  result_o
);

    // Stage 1: quotient estimate and the low bits of the product.
    logic [QHAT_W-1:0] qhat_d;
    logic [QHAT_W-1:0] qhat_q;
    logic [R_W-1:0]    prod_lo_q;
    logic              valid1_q;

    always_comb begin
        qhat_d = barrett_qhat(product_i);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            qhat_q    <= '0;
            prod_lo_q <= '0;
            valid1_q  <= 1'b0;
        end else begin
            qhat_q    <= qhat_d;
            prod_lo_q <= product_i[R_W-1:0];
            valid1_q  <= valid_i;
        end
    end

    logic [R_W-1:0] qq;

    always_comb begin
        qq = qhat_times_q(qhat_q);
    end

    // Operands seen by the subtract/correct stage.
    logic [R_W-1:0] sub_minuend;
    logic [R_W-1:0] sub_subtrahend;
    logic           sub_valid;

`ifdef RED_D_PIPE_EN
    logic [R_W-1:0] qq_q;
    logic [R_W-1:0] prod_lo2_q;
    logic           valid2_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            qq_q       <= '0;
            prod_lo2_q <= '0;
            valid2_q   <= 1'b0;
        end else begin
            qq_q       <= qq;
            prod_lo2_q <= prod_lo_q;
            valid2_q   <= valid1_q;
        end
    end

    always_comb begin
        sub_minuend    = prod_lo2_q;
        sub_subtrahend = qq_q;
        sub_valid      = valid2_q;
    end
`else
    always_comb begin
        sub_minuend    = prod_lo_q;
        sub_subtrahend = qq;
        sub_valid      = valid1_q;
    end
`endif

    // Modulo-2^25 difference equals the true remainder since it is below 3q.
    logic [R_W-1:0] r_raw;
    logic [R_W-1:0] r_once;
    logic [R_W-1:0] r_twice;

    always_comb begin
        r_raw = sub_minuend - sub_subtrahend;
    end

    red_d_csub u_csub_first (
        .value   (r_raw),
        .reduced (r_once)
    );

    red_d_csub u_csub_second (
        .value   (r_once),
        .reduced (r_twice)
    );

    // After two corrections the value is below q, so the top bits are always zero.
    logic unused_r_hi;
    assign unused_r_hi = ^r_twice[R_W-1:RES_W];

    logic [RES_W-1:0] result_q;
    logic             valid_out_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            result_q    <= '0;
            valid_out_q <= 1'b0;
        end else begin
            result_q    <= r_twice[RES_W-1:0];
            valid_out_q <= sub_valid;
        end
    end

    assign result_o = result_q;
    assign valid_o  = valid_out_q;

endmodule

// File: tb/tb_red_d.sv
// Self-checking bench for red_d: directed boundary values, streaming, resets and random
// products checked against a reference built from plain modulo arithmetic.
module tb_red_d;
    import red_d_pkg::*;

    localparam longint unsigned RefQ = 64'd8380417;

    logic        clk_i;
    logic        rst_ni;
    logic        valid_i;
    logic [45:0] product_i;
    logic        valid_o;
    logic [22:0] result_o;

    red_d dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .valid_i   (valid_i),
        .product_i (product_i),
        .valid_o   (valid_o),
        .result_o  (result_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        longint unsigned due;
        longint unsigned exp;
    } exp_t;

    exp_t            expq[$];
    longint unsigned cyc;
    int              n_tests;
    int              n_fail;

    task automatic check(input string tag, input longint unsigned got,
                         input longint unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Apply one cycle of stimulus; expected result is supplied by the caller.
    task automatic step(input logic v, input logic [45:0] p, input longint unsigned e,
                        input logic rst_n);
        exp_t item;
        valid_i   = v;
        product_i = p;
        rst_ni    = rst_n;
        @(posedge clk_i);
        cyc++;
        if (!rst_n) begin
            expq.delete();
        end else if (v) begin
            item.due = cyc + LATENCY - 1;
            item.exp = e;
            expq.push_back(item);
        end
        #1;
        if (expq.size() > 0 && expq[0].due == cyc) begin
            check("valid_o", 64'(valid_o), 1);
            check("result_o", 64'(result_o), expq[0].exp);
            check("below_q", 64'(64'(result_o) < RefQ), 1);
            void'(expq.pop_front());
        end else begin
            check("valid_idle", 64'(valid_o), 0);
        end
        if (!rst_n) begin
            check("reset_result", 64'(result_o), 0);
        end
    endtask

    function automatic longint unsigned golden(input logic [45:0] p);
        longint unsigned x;
        x = 64'(p);
        return x % RefQ;
    endfunction

    function automatic logic [45:0] rand_product();
        logic [63:0]     raw;
        longint unsigned k;
        longint unsigned off;
        raw = {$urandom, $urandom};
        case ($urandom_range(0, 4))
            0: return raw[45:0];
            1: return 46'(raw[22:0] % 23'(RefQ));
            2: return {18'h3ffff, raw[27:0]};
            3: begin
                k   = 64'($urandom_range(0, 8396806));
                off = 64'($urandom_range(0, 2));
                return 46'(k * RefQ + off);
            end
            default: begin
                k   = 64'($urandom_range(1, 8396806));
                off = 64'($urandom_range(1, 3));
                return 46'(k * RefQ - off);
            end
        endcase
    endfunction

    logic [45:0]     dir_p[7];
    longint unsigned dir_e[7];

    initial begin
        logic [45:0] p;
        n_tests   = 0;
        n_fail    = 0;
        cyc       = 0;
        rst_ni    = 1'b0;
        valid_i   = 1'b0;
        product_i = '0;

        dir_p[0] = 46'd838041;         dir_e[0] = 838041;
        dir_p[1] = 46'd8380418;        dir_e[1] = 1;
        dir_p[2] = 46'd8380417;        dir_e[2] = 0;
        dir_p[3] = 46'd0;              dir_e[3] = 0;
        dir_p[4] = 46'd96745219;       dir_e[4] = 4560632;
        dir_p[5] = 46'h3fff_ffff_ffff; dir_e[5] = 49144;
        dir_p[6] = 46'd70231372333056; dir_e[6] = 1;

        // Reset held with valid_i high must produce nothing.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, dir_p[4], 0, 1'b0);
        end

        // Directed values one at a time with idle gaps.
        for (int i = 0; i < 7; i++) begin
            step(1'b1, dir_p[i], dir_e[i], 1'b1);
            for (int j = 0; j < LATENCY + 1; j++) begin
                step(1'b0, 46'h155555555555, 0, 1'b1);
            end
        end

        // Back-to-back stream of the same values.
        for (int i = 0; i < 7; i++) begin
            step(1'b1, dir_p[i], dir_e[i], 1'b1);
        end

        // Mid-stream reset with results still in the pipeline.
        step(1'b1, dir_p[4], dir_e[4], 1'b1);
        step(1'b1, dir_p[5], dir_e[5], 1'b1);
        step(1'b1, dir_p[0], 0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, dir_p[i], dir_e[i], 1'b1);
        end

        // Random regression with random valid gaps.
        for (int i = 0; i < 20000; i++) begin
            p = rand_product();
            step(($urandom_range(0, 3) != 0), p, golden(p), 1'b1);
        end

        // Another reset mid-stream, then more random traffic.
        step(1'b1, rand_product(), 0, 1'b0);
        for (int i = 0; i < 2000; i++) begin
            p = rand_product();
            step(($urandom_range(0, 1) != 0), p, golden(p), 1'b1);
        end

        for (int i = 0; i < LATENCY + 2; i++) begin
            step(1'b0, '0, 0, 1'b1);
        end
        check("drained", 64'(expq.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
